// File: rtl/ex_mem_fwd_stage_pkg.sv
// ex_mem_pkg: shared types and widths for the EX/MEM forwarding stage.
//   XLEN     datapath width (results, store data, forward value)
//   REG_AW   register-index width
//   ex_mem_t contents of the EX/MEM pipeline register
//   lu_state_e load-use bubble FSM states
package ex_mem_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef struct packed {
      logic              valid;
      logic [XLEN-1:0]   alu_result;
      logic [XLEN-1:0]   store_data;
      logic [REG_AW-1:0] rd;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic [2:0]        funct3;
   } ex_mem_t;

   typedef enum logic {
      IDLE   = 1'b0,
      BUBBLE = 1'b1
   } lu_state_e;

endpackage

// File: rtl/ex_mem_fwd_detect.sv
// ex_mem_fwd_detect: pure comparator deciding whether the instruction in MEM
// produces a register that the instruction in EX reads.
//   mem_valid, mem_reg_write, mem_rd : registered MEM-stage producer info
//   ex_rs1, ex_rs2                   : sources of the EX-stage consumer
//   hit_a, hit_b                     : rs1 / rs2 match a live, non-x0 producer
module ex_mem_fwd_detect
   import ex_mem_pkg::*;
(
   input  logic              mem_valid,
   input  logic              mem_reg_write,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [REG_AW-1:0] ex_rs1,
   input  logic [REG_AW-1:0] ex_rs2,
   output logic              hit_a,
   output logic              hit_b
);

   // x0 is hardwired zero, so a write to it must never be forwarded.
   logic src_live;
   assign src_live = mem_valid & mem_reg_write & (mem_rd != '0);

   assign hit_a = src_live & (mem_rd == ex_rs1);
   assign hit_b = src_live & (mem_rd == ex_rs2);

endmodule

// File: rtl/ex_mem_fwd_stage.sv
// ex_mem_fwd_stage: EX/MEM pipeline register with operand-forward detection.
// Captures the EX result each cycle (1-cycle latency), exposes it as
// forward_ex_mem, raises per-operand forward selects for the instruction
// now in EX, and counts (saturating) the cycles in which any select fires.
// Optional feature macro: EX_MEM_LOAD_STALL_EN
//   defined   - a load in MEM never forwards; a dependent EX instruction gets
//               a one-cycle load_use_stall_o and a bubble is put into MEM.
//   undefined - loads forward their registered address like any result.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   ex_*_i                 EX-stage instruction fields
//   stall_i / flush_i      hold / kill the register (flush wins)
//   mem_*_o                registered MEM-stage fields
//   forward_ex_mem         forwarding value (= mem_alu_result_o)
//   fwd_a_sel_o/fwd_b_sel_o EX rs1/rs2 take forward_ex_mem
//   load_use_stall_o       hold IF/ID/EX for one cycle
//   fwd_hit_cnt_o          saturating forward-hit counter
module ex_mem_fwd_stage
   import ex_mem_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid_i,
   input  logic [XLEN-1:0]   ex_alu_result_i,
   input  logic [XLEN-1:0]   ex_store_data_i,
   input  logic [REG_AW-1:0] ex_rd_i,
   input  logic [REG_AW-1:0] ex_rs1_i,
   input  logic [REG_AW-1:0] ex_rs2_i,
   input  logic              ex_reg_write_i,
   input  logic              ex_mem_read_i,
   input  logic              ex_mem_write_i,
   input  logic [2:0]        ex_funct3_i,
   input  logic              stall_i,
   input  logic              flush_i,
   output logic              mem_valid_o,
   output logic [XLEN-1:0]   mem_alu_result_o,
   output logic [XLEN-1:0]   mem_store_data_o,
   output logic [REG_AW-1:0] mem_rd_o,
   output logic              mem_reg_write_o,
   output logic              mem_mem_read_o,
   output logic              mem_mem_write_o,
   output logic [2:0]        mem_funct3_o,
   output logic [XLEN-1:0]   forward_ex_mem,
   output logic              fwd_a_sel_o,
   output logic              fwd_b_sel_o,
   output logic              load_use_stall_o,
   output logic [CNT_W-1:0]  fwd_hit_cnt_o
);

   ex_mem_t    mem_q;
   ex_mem_t    ex_d;
   logic       hit_a, hit_b;
   logic       bubble;
   logic [CNT_W-1:0] cnt_q;

   // Controls are qualified with valid so an invalid slot can never write.
   always_comb begin
      ex_d            = '0;
      ex_d.valid      = ex_valid_i;
      ex_d.alu_result = ex_alu_result_i;
      ex_d.store_data = ex_store_data_i;
      ex_d.rd         = ex_rd_i;
      ex_d.reg_write  = ex_reg_write_i & ex_valid_i;
      ex_d.mem_read   = ex_mem_read_i  & ex_valid_i;
      ex_d.mem_write  = ex_mem_write_i & ex_valid_i;
      ex_d.funct3     = ex_funct3_i;
   end

   ex_mem_fwd_detect u_detect (
      .mem_valid     (mem_q.valid),
      .mem_reg_write (mem_q.reg_write),
      .mem_rd        (mem_q.rd),
      .ex_rs1        (ex_rs1_i),
      .ex_rs2        (ex_rs2_i),
      .hit_a         (hit_a),
      .hit_b         (hit_b)
   );

`ifdef EX_MEM_LOAD_STALL_EN
   lu_state_e state_q, state_d;
   logic      load_hit;

   // Load data only exists after MEM, so a load here is never a forward source.
   assign load_hit    = (hit_a | hit_b) & mem_q.mem_read & ~stall_i & ~flush_i;
   assign fwd_a_sel_o = hit_a & ~mem_q.mem_read;
   assign fwd_b_sel_o = hit_b & ~mem_q.mem_read;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // BUBBLE always returns: the load has moved on and forwards from MEM/WB.
   always_comb begin
      state_d          = state_q;
      load_use_stall_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_hit) begin
               load_use_stall_o = 1'b1;
               state_d          = BUBBLE;
            end
         end
         BUBBLE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bubble = load_use_stall_o;
`else
   assign fwd_a_sel_o      = hit_a;
   assign fwd_b_sel_o      = hit_b;
   assign load_use_stall_o = 1'b0;
   assign bubble           = 1'b0;
`endif

   // Flush beats stall; bubbles and flushes keep the data but drop the controls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '0;
      end else if (flush_i || (!stall_i && bubble)) begin
         mem_q.valid     <= 1'b0;
         mem_q.reg_write <= 1'b0;
         mem_q.mem_read  <= 1'b0;
         mem_q.mem_write <= 1'b0;
      end else if (!stall_i) begin
         mem_q <= ex_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if ((fwd_a_sel_o | fwd_b_sel_o) && !stall_i && !(&cnt_q))
         cnt_q <= cnt_q + 1'b1;
   end

   assign mem_valid_o      = mem_q.valid;
   assign mem_alu_result_o = mem_q.alu_result;
   assign mem_store_data_o = mem_q.store_data;
   assign mem_rd_o         = mem_q.rd;
   assign mem_reg_write_o  = mem_q.reg_write;
   assign mem_mem_read_o   = mem_q.mem_read;
   assign mem_mem_write_o  = mem_q.mem_write;
   assign mem_funct3_o     = mem_q.funct3;
   assign forward_ex_mem   = mem_q.alu_result;
   assign fwd_hit_cnt_o    = cnt_q;

endmodule

// File: tb/tb_ex_mem_fwd_stage.sv
// Directed bench for ex_mem_fwd_stage; expectations are hand-computed.
// Works in both builds: the load-use section checks whichever behaviour
// EX_MEM_LOAD_STALL_EN selects.
module tb_ex_mem_fwd_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid_i;
   logic [31:0] ex_alu_result_i, ex_store_data_i;
   logic [4:0]  ex_rd_i, ex_rs1_i, ex_rs2_i;
   logic        ex_reg_write_i, ex_mem_read_i, ex_mem_write_i;
   logic [2:0]  ex_funct3_i;
   logic        stall_i, flush_i;
   logic        mem_valid_o;
   logic [31:0] mem_alu_result_o, mem_store_data_o, forward_ex_mem;
   logic [4:0]  mem_rd_o;
   logic        mem_reg_write_o, mem_mem_read_o, mem_mem_write_o;
   logic [2:0]  mem_funct3_o;
   logic        fwd_a_sel_o, fwd_b_sel_o, load_use_stall_o;
   logic [15:0] fwd_hit_cnt_o;

   int n_chk  = 0;
   int n_pass = 0;

   ex_mem_fwd_stage #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid_i(ex_valid_i), .ex_alu_result_i(ex_alu_result_i),
      .ex_store_data_i(ex_store_data_i), .ex_rd_i(ex_rd_i),
      .ex_rs1_i(ex_rs1_i), .ex_rs2_i(ex_rs2_i),
      .ex_reg_write_i(ex_reg_write_i), .ex_mem_read_i(ex_mem_read_i),
      .ex_mem_write_i(ex_mem_write_i), .ex_funct3_i(ex_funct3_i),
      .stall_i(stall_i), .flush_i(flush_i),
      .mem_valid_o(mem_valid_o), .mem_alu_result_o(mem_alu_result_o),
      .mem_store_data_o(mem_store_data_o), .mem_rd_o(mem_rd_o),
      .mem_reg_write_o(mem_reg_write_o), .mem_mem_read_o(mem_mem_read_o),
      .mem_mem_write_o(mem_mem_write_o), .mem_funct3_o(mem_funct3_o),
      .forward_ex_mem(forward_ex_mem), .fwd_a_sel_o(fwd_a_sel_o),
      .fwd_b_sel_o(fwd_b_sel_o), .load_use_stall_o(load_use_stall_o),
      .fwd_hit_cnt_o(fwd_hit_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
   endtask

   // Advance one edge; inputs are then changed 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ex_idle();
      ex_valid_i = 0; ex_alu_result_i = 0; ex_store_data_i = 0;
      ex_rd_i = 0; ex_rs1_i = 0; ex_rs2_i = 0;
      ex_reg_write_i = 0; ex_mem_read_i = 0; ex_mem_write_i = 0; ex_funct3_i = 0;
   endtask

   task automatic ex_op(input logic [31:0] res, input logic [4:0] rd, rs1, rs2,
                        input logic rw, mr);
      ex_valid_i = 1; ex_alu_result_i = res; ex_rd_i = rd;
      ex_rs1_i = rs1; ex_rs2_i = rs2; ex_reg_write_i = rw; ex_mem_read_i = mr;
      ex_mem_write_i = 0; ex_funct3_i = 3'b010; ex_store_data_i = 0;
   endtask

   initial begin
      rst_n = 0; stall_i = 0; flush_i = 0;
      ex_idle();
      #1;
      chk("rst_valid", {31'b0, mem_valid_o}, 0);
      chk("rst_cnt", {16'b0, fwd_hit_cnt_o}, 0);
      chk("rst_lus", {31'b0, load_use_stall_o}, 0);
      tick(); tick();
      rst_n = 1;
      tick();

      // ADD x5 = 0x1234, then SUB reading x5 as rs1
      ex_op(32'h1234, 5'd5, 5'd1, 5'd2, 1, 0);
      tick();
      ex_op(32'h5555, 5'd8, 5'd5, 5'd6, 1, 0);
      #1;
      chk("add_fwd_val", forward_ex_mem, 32'h1234);
      chk("add_fwd_a", {31'b0, fwd_a_sel_o}, 1);
      chk("add_fwd_b", {31'b0, fwd_b_sel_o}, 0);
      chk("add_cnt0", {16'b0, fwd_hit_cnt_o}, 0);
      tick();
      ex_idle();
      #1;
      chk("sub_cnt1", {16'b0, fwd_hit_cnt_o}, 1);
      chk("sub_result", forward_ex_mem, 32'h5555);

      // x0 writer never forwards; rd==rs1==rs2 hits both
      ex_op(32'hAAAA, 5'd0, 5'd3, 5'd4, 1, 0);
      tick();
      ex_op(32'h77, 5'd7, 5'd0, 5'd0, 1, 0);
      #1;
      chk("x0_a", {31'b0, fwd_a_sel_o}, 0);
      chk("x0_b", {31'b0, fwd_b_sel_o}, 0);
      tick();
      ex_op(32'h33, 5'd3, 5'd7, 5'd7, 0, 0);
      #1;
      chk("both_a", {31'b0, fwd_a_sel_o}, 1);
      chk("both_b", {31'b0, fwd_b_sel_o}, 1);
      tick();
      ex_idle();
      #1;
      chk("both_cnt", {16'b0, fwd_hit_cnt_o}, 2);

      // Stall holds contents and freezes counter; flush beats stall
      ex_op(32'hBEEF, 5'd10, 5'd1, 5'd1, 1, 0);
      ex_store_data_i = 32'hCAFE; ex_funct3_i = 3'b101;
      tick();
      ex_op(32'h1111, 5'd11, 5'd10, 5'd2, 1, 0);
      stall_i = 1;
      for (int i = 0; i < 3; i++) tick();
      chk("stall_res", mem_alu_result_o, 32'hBEEF);
      chk("stall_sd", mem_store_data_o, 32'hCAFE);
      chk("stall_rd", {27'b0, mem_rd_o}, 10);
      chk("stall_f3", {29'b0, mem_funct3_o}, 3'b101);
      chk("stall_hit", {31'b0, fwd_a_sel_o}, 1);
      chk("stall_cnt", {16'b0, fwd_hit_cnt_o}, 2);
      flush_i = 1;
      tick();
      chk("flush_valid", {31'b0, mem_valid_o}, 0);
      chk("flush_rw", {31'b0, mem_reg_write_o}, 0);
      chk("flush_nohit", {31'b0, fwd_a_sel_o}, 0);
      flush_i = 0; stall_i = 0;
      ex_idle();
      tick();

      // LW x9 then ADD reading x9 as rs2
      ex_op(32'h100, 5'd9, 5'd1, 5'd2, 1, 1);
      tick();
      ex_op(32'h44, 5'd4, 5'd1, 5'd9, 1, 0);
      #1;
`ifdef EX_MEM_LOAD_STALL_EN
      chk("lu_stall", {31'b0, load_use_stall_o}, 1);
      chk("lu_fwd_b", {31'b0, fwd_b_sel_o}, 0);
      tick();
      chk("lu_bubble", {31'b0, mem_valid_o}, 0);
      chk("lu_no2nd", {31'b0, load_use_stall_o}, 0);
      chk("lu_fwd_b2", {31'b0, fwd_b_sel_o}, 0);
      tick();
      ex_idle();
      #1;
      chk("lu_add_in", {27'b0, mem_rd_o}, 4);
      chk("lu_add_vld", {31'b0, mem_valid_o}, 1);
      chk("lu_cnt", {16'b0, fwd_hit_cnt_o}, 2);
`else
      chk("nl_stall", {31'b0, load_use_stall_o}, 0);
      chk("nl_fwd_b", {31'b0, fwd_b_sel_o}, 1);
      chk("nl_fwd_val", forward_ex_mem, 32'h100);
      tick();
      ex_idle();
      #1;
      chk("nl_add_in", {27'b0, mem_rd_o}, 4);
      chk("nl_cnt", {16'b0, fwd_hit_cnt_o}, 3);
`endif

      // Continuous hit until the counter saturates
      ex_op(32'h7, 5'd7, 5'd7, 5'd2, 1, 0);
      tick();
      for (int i = 0; i < 65540; i++) @(posedge clk);
      #1;
      chk("sat_cnt", {16'b0, fwd_hit_cnt_o}, 32'hFFFF);
      tick();
      chk("sat_hold", {16'b0, fwd_hit_cnt_o}, 32'hFFFF);

      // Reset mid-traffic with a load-use pending: everything clears at once
      ex_op(32'h200, 5'd9, 5'd1, 5'd2, 1, 1);
      tick();
      ex_op(32'h44, 5'd4, 5'd9, 5'd9, 1, 0);
      #2;
      rst_n = 0;
      #1;
      chk("mrst_valid", {31'b0, mem_valid_o}, 0);
      chk("mrst_fwd", forward_ex_mem, 0);
      chk("mrst_rd", {27'b0, mem_rd_o}, 0);
      chk("mrst_cnt", {16'b0, fwd_hit_cnt_o}, 0);
      chk("mrst_lus", {31'b0, load_use_stall_o}, 0);
      chk("mrst_sel", {30'b0, fwd_a_sel_o, fwd_b_sel_o}, 0);
      tick();
      rst_n = 1;
      ex_idle();
      tick();
      chk("post_rst_valid", {31'b0, mem_valid_o}, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
